// File: rtl/i2c_target.sv
// I2C target endpoint: oversamples SCL/SDA, decodes START/STOP, matches a 7-bit
// address and turns write traffic into a byte stream and read traffic into byte requests.
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
    } state_t;

    state_t     state_q;
    logic       scl_s1_q, scl_s2_q, scl_d_q;
    logic       sda_s1_q, sda_s2_q, sda_d_q;
    logic [3:0] cnt_q;
    logic [7:0] sh_q;
    logic       rw_q;
    logic       first_q;
    logic       sda_oe_q, rx_valid_q, rx_first_q, tx_req_q, busy_q;
    logic [7:0] rx_data_q;

    logic scl_rise, scl_fall, start_det, stop_det;

    // Edges are taken between the synchronized value and its delayed copy only.
    assign scl_rise  = scl_s2_q & ~scl_d_q;
    assign scl_fall  = ~scl_s2_q & scl_d_q;
    assign start_det = scl_s2_q & scl_d_q & sda_d_q & ~sda_s2_q;
    assign stop_det  = scl_s2_q & scl_d_q & ~sda_d_q & sda_s2_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // sees the pre-edge values of the others, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_d_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_d_q    <= 1'b1;
            cnt_q      <= 4'd0;
            sh_q       <= 8'h00;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_first_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_s1_q   <= scl_in;
            scl_s2_q   <= scl_s1_q;
            scl_d_q    <= scl_s2_q;
            sda_s1_q   <= sda_in;
            sda_s2_q   <= sda_s1_q;
            sda_d_q    <= sda_s2_q;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;

            if (start_det) begin
                state_q  <= S_ADDR;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                cnt_q    <= 4'd0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR, S_WR_DATA: begin
                        if (scl_rise) begin
                            sh_q  <= {sh_q[6:0], sda_s2_q};
                            cnt_q <= cnt_q + 4'd1;
                        end else if (scl_fall && cnt_q == 4'd8) begin
                            cnt_q <= 4'd0;
                            if (state_q == S_ADDR) begin
                                if (sh_q[7:1] == ADDR) begin
                                    state_q  <= S_ADDR_ACK;
                                    rw_q     <= sh_q[0];
                                    sda_oe_q <= 1'b1;
                                    busy_q   <= 1'b1;
                                end else begin
                                    state_q <= S_WAIT_STOP;
                                    busy_q  <= 1'b0;
                                end
                            end else begin
                                state_q    <= S_WR_ACK;
                                rx_data_q  <= sh_q;
                                rx_valid_q <= 1'b1;
                                rx_first_q <= first_q;
                                first_q    <= 1'b0;
                                sda_oe_q   <= rx_ready;
                            end
                        end
                    end
                    S_ADDR_ACK, S_RD_ACK: begin
                        if (scl_rise) begin
                            if (state_q == S_RD_ACK && sda_s2_q) begin
                                state_q <= S_WAIT_STOP;
                            end else if (state_q == S_RD_ACK || rw_q) begin
                                tx_req_q <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            if (state_q == S_ADDR_ACK && !rw_q) begin
                                state_q  <= S_WR_DATA;
                                sda_oe_q <= 1'b0;
                                first_q  <= 1'b1;
                                cnt_q    <= 4'd0;
                            end else begin
                                // Bit 7 goes on the bus at the edge that ends the ACK slot.
                                state_q  <= S_RD_DATA;
                                sh_q     <= tx_data;
                                sda_oe_q <= ~tx_data[7];
                                cnt_q    <= 4'd1;
                            end
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            state_q  <= S_WR_DATA;
                            sda_oe_q <= 1'b0;
                            cnt_q    <= 4'd0;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                state_q  <= S_RD_ACK;
                                sda_oe_q <= 1'b0;
                                cnt_q    <= 4'd0;
                            end else begin
                                sda_oe_q <= ~sh_q[6];
                                sh_q     <= {sh_q[6:0], 1'b0};
                                cnt_q    <= cnt_q + 4'd1;
                            end
                        end
                    end
                    S_WAIT_STOP: sda_oe_q <= 1'b0;
                    default:     sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_first = rx_first_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a behavioural I2C controller drives the bus
// through an open-drain model; table-driven write vectors plus multi-cycle sequences.
module tb_i2c_target;

    localparam int Q = 10;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_drv, sda_drv;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_first;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_req, busy;

    int checks   = 0;
    int failures = 0;

    logic [8:0] rx_log[$];
    int         tx_cnt  = 0;
    int         oe_cnt  = 0;
    int         wide_cnt = 0;
    logic       rxv_prev = 1'b0, txr_prev = 1'b0;

    logic [7:0] tx_tab[0:3];
    int         tx_base;

    always #5 clk = ~clk;

    assign sda_bus = sda_drv & ~sda_oe;

    i2c_target #(.ADDR(7'h50)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_bus), .sda_oe(sda_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_first(rx_first), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
    );

    always @(posedge clk) begin
        if (rx_valid) rx_log.push_back({rx_first, rx_data});
        if (tx_req) tx_cnt <= tx_cnt + 1;
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if ((rx_valid && rxv_prev) || (tx_req && txr_prev)) wide_cnt <= wide_cnt + 1;
        rxv_prev <= rx_valid;
        txr_prev <= tx_req;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic present_tx();
        int k;
        k = tx_cnt - tx_base - 1;
        tx_data = (k >= 0 && k < 4) ? tx_tab[k] : 8'h00;
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_drv = b;
        wait_q();
        scl_drv = 1'b1;
        wait_q();
        s = sda_bus;
        present_tx();
        wait_q();
        scl_drv = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_q();
        scl_drv = 1'b1; wait_q();
        sda_drv = 1'b1; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(nack, s);
    endtask

    typedef struct {
        logic [7:0] abyte;
        logic [7:0] dbyte;
        logic       rdy;
        logic       exp_aack;
        logic       exp_dack;
        int         exp_rx;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic       ack;
        logic [7:0] rb;
        int         rx0, tx0, oe0;

        vecs[0] = '{8'hA0, 8'h12, 1'b1, 1'b1, 1'b1, 1};
        vecs[1] = '{8'hA2, 8'h55, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{8'hA0, 8'h99, 1'b0, 1'b1, 1'b0, 1};
        vecs[3] = '{8'h20, 8'hA0, 1'b1, 1'b0, 1'b0, 0};
        vecs[4] = '{8'hE0, 8'h5A, 1'b1, 1'b0, 1'b0, 0};

        rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; rx_ready = 1'b1; tx_data = 8'h00;
        tx_base = 0;
        for (int i = 0; i < 4; i++) tx_tab[i] = 8'h00;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("reset sda_oe", sda_oe, 0);
        check("reset busy", busy, 0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_valid", rx_valid, 0);
        check("reset rx_first", rx_first, 0);
        check("reset tx_req", tx_req, 0);

        // Single-byte write vectors: address decode, data ACK/NACK, rx strobe.
        for (int v = 0; v < 5; v++) begin
            rx0 = rx_log.size(); oe0 = oe_cnt;
            rx_ready = vecs[v].rdy;
            i2c_start();
            write_byte(vecs[v].abyte, ack);
            check($sformatf("v%0d addr ack", v), ack, vecs[v].exp_aack);
            check($sformatf("v%0d busy mid", v), busy, vecs[v].exp_aack);
            write_byte(vecs[v].dbyte, ack);
            check($sformatf("v%0d data ack", v), ack, vecs[v].exp_dack);
            i2c_stop();
            repeat (8) @(negedge clk);
            check($sformatf("v%0d rx count", v), rx_log.size() - rx0, vecs[v].exp_rx);
            if (rx_log.size() > rx0)
                check($sformatf("v%0d rx byte", v), rx_log[rx0], {1'b1, vecs[v].dbyte});
            check($sformatf("v%0d oe used", v), oe_cnt != oe0, vecs[v].exp_aack);
            check($sformatf("v%0d busy after stop", v), busy, 0);
            check($sformatf("v%0d sda_oe after stop", v), sda_oe, 0);
        end
        rx_ready = 1'b1;

        // Two-byte write: rx_first only on the first byte.
        rx0 = rx_log.size();
        i2c_start();
        write_byte(8'hA0, ack); check("w3 addr ack", ack, 1);
        write_byte(8'h12, ack); check("w3 d0 ack", ack, 1);
        write_byte(8'h34, ack); check("w3 d1 ack", ack, 1);
        check("w3 busy before stop", busy, 1);
        i2c_stop();
        repeat (8) @(negedge clk);
        check("w3 rx count", rx_log.size() - rx0, 2);
        if (rx_log.size() >= rx0 + 2) begin
            check("w3 rx 0", rx_log[rx0], {1'b1, 8'h12});
            check("w3 rx 1", rx_log[rx0 + 1], {1'b0, 8'h34});
        end
        check("w3 busy after stop", busy, 0);

        // Read three bytes: ACK, ACK, NACK.
        tx_base = tx_cnt;
        tx_tab[0] = 8'hC3; tx_tab[1] = 8'h5A; tx_tab[2] = 8'hFF; tx_tab[3] = 8'h00;
        rx0 = rx_log.size();
        i2c_start();
        write_byte(8'hA1, ack); check("rd addr ack", ack, 1);
        read_byte(1'b0, rb); check("rd byte 0", rb, 8'hC3);
        read_byte(1'b0, rb); check("rd byte 1", rb, 8'h5A);
        read_byte(1'b1, rb); check("rd byte 2", rb, 8'hFF);
        check("rd sda_oe after nack", sda_oe, 0);
        check("rd busy before stop", busy, 1);
        i2c_stop();
        repeat (8) @(negedge clk);
        check("rd tx_req count", tx_cnt - tx_base, 3);
        check("rd busy after stop", busy, 0);
        check("rd no rx", rx_log.size() - rx0, 0);

        // Repeated START: write one byte, then read one byte.
        tx_base = tx_cnt;
        tx_tab[0] = 8'h3C;
        rx0 = rx_log.size();
        i2c_start();
        write_byte(8'hA0, ack); check("sr w addr ack", ack, 1);
        write_byte(8'h07, ack); check("sr w data ack", ack, 1);
        i2c_start();
        write_byte(8'hA1, ack); check("sr r addr ack", ack, 1);
        read_byte(1'b1, rb); check("sr r byte", rb, 8'h3C);
        i2c_stop();
        repeat (8) @(negedge clk);
        check("sr rx count", rx_log.size() - rx0, 1);
        if (rx_log.size() > rx0) check("sr rx byte", rx_log[rx0], {1'b1, 8'h07});
        check("sr tx_req count", tx_cnt - tx_base, 1);

        // Reset while the target pulls SDA low for bit 3 of 0xC3.
        tx_base = tx_cnt;
        tx_tab[0] = 8'hC3;
        i2c_start();
        write_byte(8'hA1, ack); check("rst addr ack", ack, 1);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, ack);
        check("rst pre sda_oe", sda_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst sda_oe", sda_oe, 0);
        check("rst busy", busy, 0);
        tx0 = tx_cnt; oe0 = oe_cnt;
        for (int i = 0; i < 4; i++) clk_bit(1'b1, ack);
        clk_bit(1'b0, ack);
        clk_bit(1'b1, ack);
        check("rst no tx_req", tx_cnt - tx0, 0);
        check("rst no sda_oe", oe_cnt - oe0, 0);
        i2c_stop();
        tx_base = tx_cnt;
        tx_tab[0] = 8'hA5;
        i2c_start();
        write_byte(8'hA1, ack); check("post rst addr ack", ack, 1);
        read_byte(1'b1, rb); check("post rst byte", rb, 8'hA5);
        i2c_stop();
        repeat (8) @(negedge clk);
        check("post rst tx_req", tx_cnt - tx_base, 1);

        check("strobe width", wide_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
